// File: rtl/bp_me_burst_arbiter.sv
// Round-robin arbiter merging several BedRock header/data burst streams.
// A grant is held from header acceptance through the last data beat.
module bp_me_burst_arbiter #(
   parameter int num_req_p      = 2,
   parameter int header_width_p = 64,
   parameter int data_width_p   = 64,
   localparam int lg_num_req_lp = $clog2(num_req_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_req_p*header_width_p-1:0] header_i,
   input  logic [num_req_p-1:0]                header_v_i,
   input  logic [num_req_p-1:0]                header_has_data_i,
   output logic [num_req_p-1:0]                header_ready_and_o,
   input  logic [num_req_p*data_width_p-1:0]   data_i,
   input  logic [num_req_p-1:0]                data_v_i,
   input  logic [num_req_p-1:0]                data_last_i,
   output logic [num_req_p-1:0]                data_ready_and_o,
   output logic [header_width_p-1:0]           header_o,
   output logic                                header_v_o,
   input  logic                                header_ready_and_i,
   output logic [data_width_p-1:0]             data_o,
   output logic                                data_v_o,
   input  logic                                data_ready_and_i,
   output logic [lg_num_req_lp-1:0]            grant_id_o
);

   typedef enum logic [1:0] {
      e_idle,
      e_hdr_wait,
      e_data
   } state_e;

   state_e state_r, state_n;

   logic [lg_num_req_lp-1:0] grant_r, grant_n;
   logic [lg_num_req_lp-1:0] last_r, last_n;
   logic [lg_num_req_lp-1:0] winner;
   logic [lg_num_req_lp-1:0] cand;
   logic [lg_num_req_lp-1:0] sel;
   logic                     found;
   logic                     any_v;

   logic [header_width_p-1:0] hdr_a [num_req_p];
   logic [data_width_p-1:0]   dat_a [num_req_p];

   always_comb begin
      for (int k = 0; k < num_req_p; k++) begin
         hdr_a[k] = header_i[k*header_width_p +: header_width_p];
         dat_a[k] = data_i[k*data_width_p +: data_width_p];
      end
   end

   assign any_v = |header_v_i;

   // Search starts just past the last completed grant and wraps.
   always_comb begin
      winner = last_r;
      cand   = last_r;
      found  = 1'b0;
      for (int i = 1; i <= num_req_p; i++) begin
         cand = lg_num_req_lp'((int'(last_r) + i) % num_req_p);
         if (!found && header_v_i[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign sel      = (state_r == e_idle) ? winner : grant_r;
   assign header_o = hdr_a[sel];
   assign data_o   = dat_a[grant_r];

   always_comb begin
      state_n            = state_r;
      grant_n            = grant_r;
      last_n             = last_r;
      header_v_o         = 1'b0;
      header_ready_and_o = '0;
      data_v_o           = 1'b0;
      data_ready_and_o   = '0;
      grant_id_o         = last_r;

      unique case (state_r)
         e_idle: begin
            header_v_o = any_v;
            if (any_v) begin
               grant_id_o                 = winner;
               header_ready_and_o[winner] = header_ready_and_i;
               if (header_ready_and_i) begin
                  if (header_has_data_i[winner]) begin
                     grant_n = winner;
                     state_n = e_data;
                  end else begin
                     last_n = winner;
                  end
               end else begin
                  grant_n = winner;
                  state_n = e_hdr_wait;
               end
            end
         end
         e_hdr_wait: begin
            grant_id_o                  = grant_r;
            header_v_o                  = header_v_i[grant_r];
            header_ready_and_o[grant_r] = header_ready_and_i;
            // A dropped valid is illegal; fall back to idle rather than hang.
            if (!header_v_i[grant_r]) begin
               state_n = e_idle;
            end else if (header_ready_and_i) begin
               if (header_has_data_i[grant_r]) begin
                  state_n = e_data;
               end else begin
                  last_n  = grant_r;
                  state_n = e_idle;
               end
            end
         end
         e_data: begin
            grant_id_o                = grant_r;
            data_v_o                  = data_v_i[grant_r];
            data_ready_and_o[grant_r] = data_ready_and_i;
            if (data_v_i[grant_r] && data_ready_and_i
                && data_last_i[grant_r]) begin
               last_n  = grant_r;
               state_n = e_idle;
            end
         end
         default: begin
            state_n = e_idle;
         end
      endcase

      if (!reset_n_i) begin
         header_v_o         = 1'b0;
         header_ready_and_o = '0;
         data_v_o           = 1'b0;
         data_ready_and_o   = '0;
         grant_id_o         = lg_num_req_lp'(num_req_p - 1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
         grant_r <= '0;
         last_r  <= lg_num_req_lp'(num_req_p - 1);
      end else begin
         state_r <= state_n;
         grant_r <= grant_n;
         last_r  <= last_n;
      end
   end

endmodule
